// File: rtl/exp_taylor_seq_if.sv
// Handshake and result bundle for the exp_taylor_seq engine.
// master drives the request side, slave is the engine itself.
interface exp_taylor_seq_if #(
    parameter int WIDTH = 32
);
    logic                    start_i;
    logic signed [WIDTH-1:0] x_i;
    logic                    ready_o;
    logic                    busy_o;
    logic                    done_o;
    logic signed [WIDTH-1:0] result_o;
    logic                    ovf_o;
    logic [7:0]              iter_o;

    modport master (
        output start_i, x_i,
        input  ready_o, busy_o, done_o, result_o, ovf_o, iter_o
    );

    modport slave (
        input  start_i, x_i,
        output ready_o, busy_o, done_o, result_o, ovf_o, iter_o
    );
endinterface

// File: rtl/exp_taylor_seq.sv
// Sequential fixed-point e^x by Taylor series, one term per MUL/DIV pair.
// Shared multiplier and divider; saturating sum with sticky overflow.
module exp_taylor_seq #(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 16,
    parameter int TERMS      = 20,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    exp_taylor_seq_if.slave  bus
);
    localparam int W2 = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [7:0] LAST_I = 8'(TERMS - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state;
    state_t state_nx;

    logic signed [WIDTH-1:0] x_r;
    logic signed [WIDTH-1:0] term_r;
    logic signed [WIDTH-1:0] sum_r;
    logic signed [W2-1:0]    p_r;
    logic [7:0]              i_r;
    logic signed [WIDTH-1:0] result_r;
    logic                    ovf_r;

    logic signed [W2-1:0]    term_w;
    logic signed [W2-1:0]    x_w;
    logic signed [W2-1:0]    prod;
    logic signed [W2-1:0]    p_nx;
    logic signed [W2-1:0]    divisor;
    logic signed [W2-1:0]    q_full;
    logic signed [WIDTH-1:0] q;
    logic signed [WIDTH:0]   sum_ext;
    logic signed [WIDTH-1:0] sum_sat;
    logic                    q_clip;
    logic                    s_clip;
    logic                    last;

    // Term update datapath: product, floor shift, truncating divide, saturation.
    always_comb begin
        term_w  = {{WIDTH{term_r[WIDTH-1]}}, term_r};
        x_w     = {{WIDTH{x_r[WIDTH-1]}}, x_r};
        prod    = term_w * x_w;
        p_nx    = prod >>> FRAC;
        divisor = {{(W2-8){1'b0}}, i_r};
        q_full  = p_r / divisor;
        q_clip  = !((&q_full[W2-1:WIDTH-1]) || !(|q_full[W2-1:WIDTH-1]));
        q       = q_full[WIDTH-1:0];
        if (q_clip) begin
            q = q_full[W2-1] ? MINV : MAXV;
        end
        sum_ext = {sum_r[WIDTH-1], sum_r} + {q[WIDTH-1], q};
        s_clip  = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
        sum_sat = sum_ext[WIDTH-1:0];
        if (s_clip) begin
            sum_sat = sum_ext[WIDTH] ? MINV : MAXV;
        end
        last = (i_r == LAST_I) || q_clip || s_clip
            || ((EARLY_EXIT != 0) && (q == '0));
    end

    // Sequencer next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start_i) state_nx = MUL;
            MUL:  state_nx = DIV;
            DIV:  state_nx = last ? DONE : MUL;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Operand, term, sum and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r      <= '0;
            term_r   <= '0;
            sum_r    <= '0;
            p_r      <= '0;
            i_r      <= '0;
            result_r <= '0;
            ovf_r    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        x_r      <= bus.x_i;
                        term_r   <= ONE;
                        sum_r    <= ONE;
                        i_r      <= 8'd1;
                        ovf_r    <= 1'b0;
                        result_r <= '0;
                    end
                end
                MUL: p_r <= p_nx;
                DIV: begin
                    term_r <= q;
                    sum_r  <= sum_sat;
                    i_r    <= i_r + 8'd1;
                    if (q_clip || s_clip) ovf_r <= 1'b1;
                    if (last) result_r <= sum_sat;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o  = (state == IDLE);
    assign bus.busy_o   = (state == MUL) || (state == DIV);
    assign bus.done_o   = (state == DONE);
    assign bus.result_o = result_r;
    assign bus.ovf_o    = ovf_r;
    assign bus.iter_o   = bus.busy_o ? i_r : 8'd0;
endmodule

// File: tb/tb_exp_taylor_seq.sv
// Directed bench for exp_taylor_seq: integer and Q16.16 builds,
// latency, saturation, mid-run reset and ignored start while busy.
module tb_exp_taylor_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exp_taylor_seq_if #(.WIDTH(32)) ia ();
    exp_taylor_seq_if #(.WIDTH(32)) ib ();
    exp_taylor_seq_if #(.WIDTH(32)) ic ();

    exp_taylor_seq #(.WIDTH(32), .FRAC(0), .TERMS(20), .EARLY_EXIT(0))
        ua (.clk(clk), .rst(rst), .bus(ia.slave));
    exp_taylor_seq #(.WIDTH(32), .FRAC(0), .TERMS(20), .EARLY_EXIT(1))
        ub (.clk(clk), .rst(rst), .bus(ib.slave));
    exp_taylor_seq #(.WIDTH(32), .FRAC(16), .TERMS(20), .EARLY_EXIT(1))
        uc (.clk(clk), .rst(rst), .bus(ic.slave));

    logic [2:0]  st;
    logic [31:0] xv;
    logic [2:0]  done_v, ready_v, busy_v, ovf_v;
    logic [31:0] res_v [3];
    logic [7:0]  iter_v [3];

    assign ia.start_i = st[0];
    assign ib.start_i = st[1];
    assign ic.start_i = st[2];
    assign ia.x_i = xv;
    assign ib.x_i = xv;
    assign ic.x_i = xv;
    assign done_v  = {ic.done_o,  ib.done_o,  ia.done_o};
    assign ready_v = {ic.ready_o, ib.ready_o, ia.ready_o};
    assign busy_v  = {ic.busy_o,  ib.busy_o,  ia.busy_o};
    assign ovf_v   = {ic.ovf_o,   ib.ovf_o,   ia.ovf_o};
    assign res_v[0] = ia.result_o;
    assign res_v[1] = ib.result_o;
    assign res_v[2] = ic.result_o;
    assign iter_v[0] = ia.iter_o;
    assign iter_v[1] = ib.iter_o;
    assign iter_v[2] = ic.iter_o;

    typedef struct {
        int          s;
        logic [31:0] x;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t tbl [9];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input logic [31:0] act,
                           input logic [31:0] lo, input logic [31:0] hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0h want %0h..%0h", nm, act, lo, hi);
        end
    endtask

    task automatic run_op(input int s, input logic [31:0] x,
                          output int cyc, output logic [31:0] r,
                          output logic o, output bit seen);
        @(posedge clk); #1;
        xv = x;
        st[s] = 1'b1;
        @(posedge clk); #1;
        st[s] = 1'b0;
        cyc = 0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (done_v[s]) seen = 1'b1;
        end
        r = res_v[s];
        o = ovf_v[s];
    endtask

    initial begin
        int          cyc;
        logic [31:0] r;
        logic        o;
        bit          seen;
        string       nm;

        tbl[0] = '{0, 32'd3,        32'd16,       32'd16,       1'b0, 38};
        tbl[1] = '{1, 32'd3,        32'd16,       32'd16,       1'b0, 12};
        tbl[2] = '{2, 32'h00030000, 32'h001415CF, 32'h001415E3, 1'b0, -1};
        tbl[3] = '{2, 32'hFFFF0000, 32'h00005E19, 32'h00005E41, 1'b0, 18};
        tbl[4] = '{2, 32'h00000000, 32'h00010000, 32'h00010000, 1'b0, 2};
        tbl[5] = '{2, 32'h000B0000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 22};
        tbl[6] = '{2, 32'h00010000, 32'h0002B7CD, 32'h0002B7F5, 1'b0, 18};
        tbl[7] = '{0, 32'd0,        32'd1,        32'd1,        1'b0, 38};
        tbl[8] = '{1, 32'hFFFFFFFF, 32'd0,        32'd0,        1'b0, 4};

        st = '0;
        xv = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_ready", 32'(ready_v[0]), 32'd1);
        chk("rst_busy",  32'(busy_v[0]),  32'd0);
        chk("rst_done",  32'(done_v[0]),  32'd0);
        chk("rst_result", res_v[0],       32'd0);
        chk("rst_ovf",   32'(ovf_v[0]),   32'd0);
        chk("rst_iter",  32'(iter_v[0]),  32'd0);

        for (int v = 0; v < 9; v++) begin
            run_op(tbl[v].s, tbl[v].x, cyc, r, o, seen);
            nm = $sformatf("v%0d", v);
            chk({nm, "_seen"}, 32'(seen), 32'd1);
            chk_rng({nm, "_result"}, r, tbl[v].lo, tbl[v].hi);
            chk({nm, "_ovf"}, 32'(o), 32'(tbl[v].ovf));
            if (tbl[v].lat >= 0) chk({nm, "_lat"}, cyc, tbl[v].lat);
            @(posedge clk); #1;
            chk({nm, "_pulse"}, 32'(done_v[tbl[v].s]), 32'd0);
            chk({nm, "_ready"}, 32'(ready_v[tbl[v].s]), 32'd1);
        end

        // start while busy must be dropped
        @(posedge clk); #1;
        xv = 32'd3;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        chk("acc_busy", 32'(busy_v[0]), 32'd1);
        chk("acc_clear", res_v[0], 32'd0);
        chk("acc_iter", 32'(iter_v[0]), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        xv = 32'd5;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        cyc = 5;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (done_v[0]) seen = 1'b1;
        end
        chk("busy_seen", 32'(seen), 32'd1);
        chk("busy_result", res_v[0], 32'd16);
        chk("busy_lat", cyc, 38);
        @(posedge clk); #1;

        // reset in the middle of a run
        xv = 32'd3;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            if (iter_v[0] == 8'd5) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("mid_iter5", 32'(seen), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_ready", 32'(ready_v[0]), 32'd1);
        chk("mid_busy",  32'(busy_v[0]),  32'd0);
        chk("mid_iter",  32'(iter_v[0]),  32'd0);
        seen = 1'b0;
        for (int k = 0; k < 45; k++) begin
            if (done_v[0]) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("mid_nodone", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
